// File: rtl/flash_boot_loader_if.sv
// Bundle of the boot loader's control, SPI-engine and memory-write signals.
// master = the boot loader, slave = the surrounding system (CPU decode, SPI master, memory).
interface flash_boot_loader_if #(
  parameter int LEN_W  = 16,
  parameter int MEM_AW = 19
);
  logic              start;
  logic [23:0]       flash_addr;
  logic [MEM_AW-1:0] dest_addr;
  logic [LEN_W-1:0]  byte_count;
  logic              busy;
  logic              done;
  logic              cpu_req;
  logic              cpu_gnt;
  logic              spi_start;
  logic [7:0]        spi_tx;
  logic [7:0]        spi_rx;
  logic              spi_busy;
  logic              seq_flash_cs_n;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_we;

  modport master (
    input  start, flash_addr, dest_addr, byte_count, cpu_req, spi_rx, spi_busy,
    output busy, done, cpu_gnt, spi_start, spi_tx, seq_flash_cs_n, mem_addr, mem_data, mem_we
  );

  modport slave (
    output start, flash_addr, dest_addr, byte_count, cpu_req, spi_rx, spi_busy,
    input  busy, done, cpu_gnt, spi_start, spi_tx, seq_flash_cs_n, mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/flash_boot_loader.sv
// Flash-to-memory copy sequencer sharing the SPI master with the CPU path.
// Optional FLASH_FAST_READ_EN: use FAST READ (0x0B) with one dummy byte after the address.
module flash_boot_loader #(
  parameter int LEN_W  = 16,
  parameter int MEM_AW = 19
) (
  input logic                 clk,
  input logic                 rst_n,
  flash_boot_loader_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, WAIT_BUS, CMD, A2, A1, A0,
`ifdef FLASH_FAST_READ_EN
    DUMMY,
`endif
    DATA, WR, FINISH
  } state_t;

`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] READ_CMD = 8'h0B;
`else
  localparam logic [7:0] READ_CMD = 8'h03;
`endif

  state_t            state_reg, state_next;
  logic [1:0]        phase_reg, phase_next;
  logic [23:0]       faddr_reg, faddr_next;
  logic [MEM_AW-1:0] addr_reg, addr_next;
  logic [LEN_W-1:0]  rem_reg, rem_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              gnt_reg, gnt_next;
  logic              spi_start_reg, spi_start_next;
  logic [7:0]        spi_tx_reg, spi_tx_next;
  logic              cs_n_reg, cs_n_next;
  logic [MEM_AW-1:0] mem_addr_reg, mem_addr_next;
  logic [7:0]        mem_data_reg, mem_data_next;
  logic              mem_we_reg, mem_we_next;
  logic [7:0]        tx_byte;
  state_t            after_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      phase_reg     <= 2'd0;
      faddr_reg     <= '0;
      addr_reg      <= '0;
      rem_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      gnt_reg       <= 1'b1;
      spi_start_reg <= 1'b0;
      spi_tx_reg    <= 8'hFF;
      cs_n_reg      <= 1'b1;
      mem_addr_reg  <= '0;
      mem_data_reg  <= '0;
      mem_we_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      faddr_reg     <= faddr_next;
      addr_reg      <= addr_next;
      rem_reg       <= rem_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      gnt_reg       <= gnt_next;
      spi_start_reg <= spi_start_next;
      spi_tx_reg    <= spi_tx_next;
      cs_n_reg      <= cs_n_next;
      mem_addr_reg  <= mem_addr_next;
      mem_data_reg  <= mem_data_next;
      mem_we_reg    <= mem_we_next;
    end
  end

  // Byte to shift out and the state that follows it for each transfer state.
  always_comb begin
    tx_byte    = 8'hFF;
    after_byte = DATA;
    case (state_reg)
      CMD: begin tx_byte = READ_CMD;         after_byte = A2; end
      A2:  begin tx_byte = faddr_reg[23:16]; after_byte = A1; end
      A1:  begin tx_byte = faddr_reg[15:8];  after_byte = A0; end
`ifdef FLASH_FAST_READ_EN
      A0:  begin tx_byte = faddr_reg[7:0];   after_byte = DUMMY; end
`else
      A0:  begin tx_byte = faddr_reg[7:0];   after_byte = DATA; end
`endif
      DATA:    after_byte = WR;
      default: after_byte = DATA;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    faddr_next     = faddr_reg;
    addr_next      = addr_reg;
    rem_next       = rem_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    gnt_next       = gnt_reg;
    spi_start_next = 1'b0;
    spi_tx_next    = spi_tx_reg;
    cs_n_next      = cs_n_reg;
    mem_addr_next  = mem_addr_reg;
    mem_data_next  = mem_data_reg;
    mem_we_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        gnt_next = 1'b1;
        if (bus.start) begin
          faddr_next = bus.flash_addr;
          addr_next  = bus.dest_addr;
          rem_next   = bus.byte_count;
          busy_next  = 1'b1;
          state_next = (bus.byte_count == '0) ? FINISH : WAIT_BUS;
        end
      end
      WAIT_BUS: begin
        // Only take the engine between CPU bytes, never in the middle of one.
        if (!bus.cpu_req && !bus.spi_busy) begin
          gnt_next   = 1'b0;
          cs_n_next  = 1'b0;
          phase_next = 2'd0;
          state_next = CMD;
        end
      end
      WR: begin
        mem_we_next   = 1'b1;
        mem_addr_next = addr_reg;
        addr_next     = addr_reg + MEM_AW'(1);
        rem_next      = rem_reg - LEN_W'(1);
        state_next    = (rem_reg == LEN_W'(1)) ? FINISH : DATA;
      end
      FINISH: begin
        cs_n_next  = 1'b1;
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: begin
        // Phases: 0 launch, 1 pulse cycle, 2 busy not yet trusted, 3 wait for idle.
        case (phase_reg)
          2'd0: begin
            spi_start_next = 1'b1;
            spi_tx_next    = tx_byte;
            phase_next     = 2'd1;
          end
          2'd1: phase_next = 2'd2;
          2'd2: phase_next = 2'd3;
          default: begin
            if (!bus.spi_busy) begin
              phase_next = 2'd0;
              state_next = after_byte;
              if (state_reg == DATA) mem_data_next = bus.spi_rx;
            end
          end
        endcase
      end
    endcase
  end

  assign bus.busy           = busy_reg;
  assign bus.done           = done_reg;
  assign bus.cpu_gnt        = gnt_reg;
  assign bus.spi_start      = spi_start_reg;
  assign bus.spi_tx         = spi_tx_reg;
  assign bus.seq_flash_cs_n = cs_n_reg;
  assign bus.mem_addr       = mem_addr_reg;
  assign bus.mem_data       = mem_data_reg;
  assign bus.mem_we         = mem_we_reg;
endmodule

// File: tb/tb_flash_boot_loader.sv
// Scoreboard bench for flash_boot_loader: SPI slave model, expected tx/write queues.
`timescale 1ns/1ps
module tb_flash_boot_loader;
  localparam int LEN_W  = 16;
  localparam int MEM_AW = 19;
`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] RD_CMD = 8'h0B;
  localparam int         HDR    = 5;
`else
  localparam logic [7:0] RD_CMD = 8'h03;
  localparam int         HDR    = 4;
`endif

  typedef struct {
    logic [MEM_AW-1:0] a;
    logic [7:0]        d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  flash_boot_loader_if #(.LEN_W(LEN_W), .MEM_AW(MEM_AW)) bus();
  flash_boot_loader #(.LEN_W(LEN_W), .MEM_AW(MEM_AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0] exp_tx[$];
  logic [7:0] rx_q[$];
  wr_t        exp_wr[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int spi_cnt = 0, we_cnt = 0, done_cnt = 0;
  int last_we_cyc = 0, last_done_cyc = 0;
  bit cs_low_seen = 0, gnt_overlap = 0;
  logic [1:0] sp_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] next_rx();
    if (rx_q.size() > 0) return rx_q.pop_front();
    return 8'h5A;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // SPI slave: busy for 4 cycles after the launch edge, rx valid as busy drops.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.spi_busy <= 1'b0;
      bus.spi_rx   <= 8'h00;
      sp_cnt       <= 2'd0;
    end else if (bus.spi_start) begin
      bus.spi_busy <= 1'b1;
      sp_cnt       <= 2'd3;
    end else if (bus.spi_busy) begin
      if (sp_cnt == 2'd0) begin
        bus.spi_busy <= 1'b0;
        bus.spi_rx   <= next_rx();
      end else begin
        sp_cnt <= sp_cnt - 2'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.spi_start) begin
        spi_cnt++;
        if (exp_tx.size() == 0) check_eq("tx_unexpected", 32'(exp_tx.size()), 32'd1);
        else check_eq("spi_tx", {24'd0, bus.spi_tx}, {24'd0, exp_tx.pop_front()});
      end
      if (bus.mem_we) begin
        wr_t w;
        we_cnt++;
        last_we_cyc = cyc;
        $display("mem write addr=%05h data=%02h", bus.mem_addr, bus.mem_data);
        if (exp_wr.size() == 0) check_eq("wr_unexpected", 32'(exp_wr.size()), 32'd1);
        else begin
          w = exp_wr.pop_front();
          check_eq("mem_addr", 32'(bus.mem_addr), 32'(w.a));
          check_eq("mem_data", {24'd0, bus.mem_data}, {24'd0, w.d});
        end
      end
      if (!bus.seq_flash_cs_n) begin
        cs_low_seen = 1;
        if (bus.cpu_gnt) gnt_overlap = 1;
      end
      if (bus.done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic queue_copy(input logic [23:0] fa, input logic [MEM_AW-1:0] da,
                            input int n, input bit fixed);
    logic [7:0] d;
    exp_tx.push_back(RD_CMD);
    exp_tx.push_back(fa[23:16]);
    exp_tx.push_back(fa[15:8]);
    exp_tx.push_back(fa[7:0]);
`ifdef FLASH_FAST_READ_EN
    exp_tx.push_back(8'hFF);
`endif
    for (int i = 0; i < HDR; i++) rx_q.push_back(8'(8'h10 + i));
    for (int i = 0; i < n; i++) begin
      d = fixed ? 8'(8'hAA + 8'h11 * i) : 8'($urandom);
      exp_tx.push_back(8'hFF);
      rx_q.push_back(d);
      exp_wr.push_back('{a: MEM_AW'(da + MEM_AW'(i)), d: d});
    end
  endtask

  task automatic pulse_start(input logic [23:0] fa, input logic [MEM_AW-1:0] da, input int n);
    @(posedge clk); #1;
    bus.flash_addr = fa;
    bus.dest_addr  = da;
    bus.byte_count = LEN_W'(n);
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit had_writes);
    bit got = 0;
    int d0 = done_cnt;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (bus.done) begin got = 1; break; end
    end
    check_eq({tag, "_done_seen"}, 32'(got), 32'd1);
    @(negedge clk);
    check_eq({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    if (had_writes) check_eq({tag, "_we_to_done"}, 32'(last_done_cyc - last_we_cyc), 32'd1);
    check_eq({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_done_after"}, 32'(bus.done), 32'd0);
    check_eq({tag, "_gnt_after"}, 32'(bus.cpu_gnt), 32'd1);
    check_eq({tag, "_cs_after"}, 32'(bus.seq_flash_cs_n), 32'd1);
    check_eq({tag, "_tx_left"}, 32'(exp_tx.size()), 32'd0);
    check_eq({tag, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
    $display("copy %s finished at cycle %0d", tag, cyc);
  endtask

  task automatic run_copy(input string tag, input logic [23:0] fa,
                          input logic [MEM_AW-1:0] da, input int n, input bit fixed);
    queue_copy(fa, da, n, fixed);
    pulse_start(fa, da, n);
    wait_done(tag, 1'b1);
  endtask

  initial begin
    int s0, w0, d0;
    bit bad;
    bit reached;
    bus.start = 1'b0; bus.flash_addr = '0; bus.dest_addr = '0;
    bus.byte_count = '0; bus.cpu_req = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_gnt", 32'(bus.cpu_gnt), 32'd1);
    check_eq("rst_spi_start", 32'(bus.spi_start), 32'd0);
    check_eq("rst_spi_tx", 32'(bus.spi_tx), 32'hFF);
    check_eq("rst_cs", 32'(bus.seq_flash_cs_n), 32'd1);
    check_eq("rst_we", 32'(bus.mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check_eq("rst_mem_data", 32'(bus.mem_data), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_copy("basic4", 24'h012345, MEM_AW'(19'h00100), 4, 1'b1);

    // Zero-length copy: done two cycles after start, engine never touched.
    s0 = spi_cnt; w0 = we_cnt; cs_low_seen = 0;
    pulse_start(24'hABCDEF, MEM_AW'(19'h00200), 0);
    @(negedge clk);
    check_eq("zero_busy_c1", 32'(bus.busy), 32'd1);
    check_eq("zero_done_c1", 32'(bus.done), 32'd0);
    @(negedge clk);
    check_eq("zero_done_c2", 32'(bus.done), 32'd1);
    check_eq("zero_busy_c2", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("zero_spi", 32'(spi_cnt - s0), 32'd0);
    check_eq("zero_we", 32'(we_cnt - w0), 32'd0);
    check_eq("zero_cs", 32'(cs_low_seen), 32'd0);

    // CPU holds the bus when start arrives.
    bus.cpu_req = 1'b1;
    queue_copy(24'h00F0F0, MEM_AW'(19'h01000), 2, 1'b0);
    pulse_start(24'h00F0F0, MEM_AW'(19'h01000), 2);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.seq_flash_cs_n || !bus.cpu_gnt || bus.spi_start) bad = 1;
    end
    check_eq("cpu_hold", 32'(bad), 32'd0);
    check_eq("cpu_hold_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1 bus.cpu_req = 1'b0;
    wait_done("cpu_req", 1'b1);

    run_copy("wrap", 24'h7FFFFE, {MEM_AW{1'b1}}, 2, 1'b0);
    run_copy("single", 24'h102030, MEM_AW'(19'h2ABCD), 1, 1'b0);

    // Abort a long copy part-way through its data phase.
    w0 = we_cnt;
    queue_copy(24'h000100, MEM_AW'(19'h03000), 100, 1'b0);
    pulse_start(24'h000100, MEM_AW'(19'h03000), 100);
    reached = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (we_cnt - w0 >= 3) begin reached = 1; break; end
    end
    check_eq("abort_progress", 32'(reached), 32'd1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check_eq("abort_cs", 32'(bus.seq_flash_cs_n), 32'd1);
    check_eq("abort_gnt", 32'(bus.cpu_gnt), 32'd1);
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    exp_tx.delete(); exp_wr.delete(); rx_q.delete();
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("abort_no_done", 32'(done_cnt - d0), 32'd0);
    $display("abort applied at cycle %0d", cyc);

    run_copy("after_abort", 24'h0A0B0C, MEM_AW'(19'h04000), 3, 1'b0);
    for (int r = 0; r < 2; r++)
      run_copy("random", 24'($urandom), MEM_AW'($urandom), int'($urandom_range(1, 6)), 1'b0);

    check_eq("gnt_cs_overlap", 32'(gnt_overlap), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/flash_boot_loader.md
Name: flash_boot_loader

Overview:
- Hardware sequencer that shares the single SPI master between CPU port accesses and an automatic flash-to-memory block copy.
- On `start`, it takes the SPI engine and asserts flash CS. It issues a flash READ command with a 24-bit address, streams `byte_count` bytes into a memory write port, then returns the SPI engine to the CPU path.
- Sits between the ZXUNO register/DIVMMC port decode and the SPI master, in front of the flash/SD CS logic.

Parameters:
- LEN_W, 16, width of `byte_count`. Maximum transfer is 2^LEN_W-1 bytes.
- MEM_AW, 19, width of the destination memory address.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a copy; sampled every cycle
- flash_addr  in  24  flash start address, latched on accepted start
- dest_addr  in  MEM_AW  memory start address, latched on accepted start
- byte_count  in  LEN_W  number of bytes to copy, latched on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of copy
- cpu_req  in  1  CPU path wants the SPI engine (flash/SD CS or SPI port activity)
- cpu_gnt  out  1  CPU path owns the SPI engine; CPU strobes are gated by it
- spi_start  out  1  one-cycle launch of an 8-bit SPI transfer (sequencer-owned)
- spi_tx  out  8  byte to shift out
- spi_rx  in  8  byte shifted in; valid when spi_busy low after a transfer
- spi_busy  in  1  SPI transfer in progress
- seq_flash_cs_n  out  1  flash CS request from sequencer; ANDed with CPU CS downstream
- mem_addr  out  MEM_AW  write address
- mem_data  out  8  write data
- mem_we  out  1  one-cycle write strobe

Behaviour:
- Reset values: busy=0, done=0, cpu_gnt=1, spi_start=0, spi_tx=8'hFF, seq_flash_cs_n=1, mem_we=0, mem_addr=0, mem_data=0.
- Reset mid-copy aborts immediately: CS deasserts asynchronously and no done pulse is produced.
- States: IDLE, WAIT_BUS, CMD, A2, A1, A0, [DUMMY], DATA, WR, FINISH.
- IDLE:
  - start=1 latches the inputs and sets busy=1 the next cycle.
  - If byte_count==0: go directly to FINISH; CS is never asserted.
  - Otherwise go to WAIT_BUS.
  - start while busy is ignored.
- WAIT_BUS:
  - Wait until cpu_req==0 and spi_busy==0.
  - Then drop cpu_gnt, drop seq_flash_cs_n, and go to CMD.
  - cpu_gnt stays high while the CPU still requests. The CPU is never preempted mid-byte.
- Arbitration:
  - While busy and past WAIT_BUS, cpu_gnt=0.
  - cpu_req is ignored until FINISH; it then gets the bus the cycle after done.
  - In IDLE, cpu_gnt=1 unconditionally.
  - Simultaneous start and cpu_req: start is accepted but waits in WAIT_BUS.
- Byte transfer rule (CMD/A2/A1/A0/DUMMY/DATA):
  - Present spi_tx and pulse spi_start for 1 cycle.
  - Ignore spi_busy in the following cycle.
  - Then wait for spi_busy==0; the byte is complete.
- Byte sequence:
  - CMD sends 8'h03.
  - A2/A1/A0 send address bits [23:16], [15:8], [7:0].
  - DATA sends 8'hFF and captures spi_rx into mem_data.
- WR:
  - mem_we=1 for one cycle with mem_addr = current address.
  - Then increment the address (wraps modulo 2^MEM_AW) and decrement the remaining count.
  - remaining==0 goes to FINISH, else back to DATA.
- Flash address is not incremented internally; the flash auto-increments. Wrap past 24'hFFFFFF is the flash's responsibility.
- FINISH:
  - seq_flash_cs_n=1, done=1 for one cycle, busy=0.
  - cpu_gnt=1 from the next cycle.
  - Return to IDLE.
- Latency: byte_count=N>0 with a free bus gives first mem_we after 5 SPI transfers. done follows the last mem_we by exactly 1 cycle.

Optional Feature:
- Macro FLASH_FAST_READ_EN.
- Defined: CMD sends 8'h0B, and a DUMMY state sends one 8'hFF byte after A0, with the result discarded, before DATA.
- Undefined: CMD sends 8'h03, and the DUMMY state does not exist.

Test Plan:
- Reset, then start with flash_addr=24'h012345, dest_addr=0x00100, count=4, SPI model returning AA,BB,CC,DD:
  - tx sequence 03,01,23,45,FF×4.
  - mem writes 0x00100..0x00103 = AA..DD.
  - single done pulse; busy low after.
- start with count=0 → done 2 cycles after start; seq_flash_cs_n never low; no spi_start, no mem_we.
- cpu_req high when start arrives, released 20 cycles later → seq_flash_cs_n stays 1 and cpu_gnt stays 1 until cpu_req falls; copy then proceeds.
- dest_addr=2^MEM_AW-1, count=2 → writes at max address then 0.
- rst_n low during DATA of a 100-byte copy → seq_flash_cs_n=1 and cpu_gnt=1 immediately; no done; a new start completes normally.
- FLASH_FAST_READ_EN defined, count=1 → tx sequence 0B,A2,A1,A0,FF,FF; exactly one mem_we, carrying the sixth rx byte.
